mem_ctrl: RTL and testbench

Memory controller that owns the single byte-wide RAM port of the RISC-V core and shares it between two requesters: instruction fetch (IF, word reads only) and the MEM stage (byte/half/word loads and stores). It arbitrates when idle, serialises each access into little-endian byte transfers on the RAM port, assembles or splits data, and returns a one-cycle done pulse. It sits between the pipeline stages and the top-level RAM pins in the CPU wrapper.

---
 rtl/mem_ctrl_if.sv | 42 ++++
 rtl/mem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response and RAM-pin bundle of the memory controller.
// The master side is the environment (pipeline stages plus the RAM); the
// slave side is the controller itself.
interface mem_ctrl_if;
    // instruction fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_done;
    logic [31:0] if_inst;
    // MEM stage port
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    // byte-wide RAM pins
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din;

    modport master (
        output if_req, if_addr, if_flush,
        input  if_done, if_inst,
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  mem_done, mem_rdata,
        input  ram_a, ram_dout, ram_wr,
        output ram_din
    );

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_done, if_inst,
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output mem_done, mem_rdata,
        output ram_a, ram_dout, ram_wr,
        input  ram_din
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: owns the core's single byte-wide RAM port and shares it between
// instruction fetch (word reads) and the MEM stage (byte/half/word loads and
// stores). Each access is serialised into little-endian byte transfers and
// finished with a one-cycle done pulse to the owning requester.
module mem_ctrl (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state_q,     state_d;
    logic [2:0]  cnt_q,       cnt_d;       // edges elapsed since the grant edge
    logic [2:0]  nbytes_q,    nbytes_d;    // bytes in the current access (1/2/4)
    logic        own_mem_q,   own_mem_d;   // 1 = MEM owns the port, 0 = IF
    logic [31:0] wdata_q,     wdata_d;
    logic [31:0] acc_q,       acc_d;       // read bytes assembled so far
    logic [31:0] ram_a_q,     ram_a_d;
    logic [7:0]  ram_dout_q,  ram_dout_d;
    logic        ram_wr_q,    ram_wr_d;
    logic        if_done_q,   if_done_d;
    logic [31:0] if_inst_q,   if_inst_d;
    logic        mem_done_q,  mem_done_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic [2:0]  step;        // number of the edge being computed, counted from grant
    logic [1:0]  cap_idx;     // byte lane captured at this edge during READ
    logic [2:0]  mem_nbytes;

    // State and registered outputs; reset clears everything, dropping ram_wr at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            nbytes_q    <= '0;
            own_mem_q   <= 1'b0;
            wdata_q     <= '0;
            acc_q       <= '0;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            if_inst_q   <= '0;
            mem_done_q  <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nbytes_q    <= nbytes_d;
            own_mem_q   <= own_mem_d;
            wdata_q     <= wdata_d;
            acc_q       <= acc_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_done_q   <= if_done_d;
            if_inst_q   <= if_inst_d;
            mem_done_q  <= mem_done_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Arbitration, byte sequencing and data assembly for the next edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nbytes_d    = nbytes_q;
        own_mem_d   = own_mem_q;
        wdata_d     = wdata_q;
        acc_d       = acc_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = '0;
        ram_wr_d    = 1'b0;
        if_done_d   = 1'b0;
        if_inst_d   = if_inst_q;
        mem_done_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;
        step        = cnt_q + 3'd1;
        cap_idx     = 2'(step - 3'd2);

        case (bus.mem_size)
            2'b00:   mem_nbytes = 3'd1;
            2'b01:   mem_nbytes = 3'd2;
            default: mem_nbytes = 3'd4;
        endcase

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // MEM holds the older instruction, so it wins a tie
                if (bus.mem_req) begin
                    own_mem_d = 1'b1;
                    nbytes_d  = mem_nbytes;
                    wdata_d   = bus.mem_wdata;
                    ram_a_d   = bus.mem_addr;
                    acc_d     = '0;
                    if (bus.mem_we) begin
                        state_d    = WRITE;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = bus.mem_wdata[7:0];
                    end else begin
                        state_d = READ;
                    end
                end else if (bus.if_req && !bus.if_flush) begin
                    own_mem_d = 1'b0;
                    nbytes_d  = 3'd4;
                    ram_a_d   = bus.if_addr;
                    acc_d     = '0;
                    state_d   = READ;
                end
            end

            READ: begin
                cnt_d = step;
                if (step < nbytes_q) begin
                    ram_a_d = ram_a_q + 32'd1;
                end
                // RAM read is registered: the byte addressed at edge k is captured at k+2
                if (step >= 3'd2) begin
                    acc_d[{cap_idx, 3'b000} +: 8] = bus.ram_din;
                end
                if (step == nbytes_q + 3'd1) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (own_mem_q) begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = acc_d;
                    end else begin
                        if_done_d = 1'b1;
                        if_inst_d = acc_d;
                    end
                end
                // A taken branch abandons the fetch, even on its final edge
                if (!own_mem_q && bus.if_flush) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    if_done_d = 1'b0;
                    if_inst_d = if_inst_q;
                end
            end

            WRITE: begin
                cnt_d = step;
                if (step < nbytes_q) begin
                    ram_a_d    = ram_a_q + 32'd1;
                    ram_dout_d = wdata_q[{step[1:0], 3'b000} +: 8];
                    ram_wr_d   = 1'b1;
                end else begin
                    state_d    = DONE;
                    cnt_d      = '0;
                    mem_done_d = 1'b1;
                end
            end

            DONE: begin
                // no grant at this edge: requesters drop req on seeing done
                state_d = IDLE;
                cnt_d   = '0;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.if_done   = if_done_q;
    assign bus.if_inst   = if_inst_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.ram_a     = ram_a_q;
    assign bus.ram_dout  = ram_dout_q;
    assign bus.ram_wr    = ram_wr_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenarios plus randomized accesses against a
// byte-addressed reference memory and per-access timing expectations.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst;

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // physical RAM contents (written only by the DUT) and the reference image
    logic [7:0]  ram_arr   [logic [31:0]];
    logic [7:0]  model_arr [logic [31:0]];
    logic [31:0] last_if_inst;
    logic [31:0] last_mem_rdata;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] phys_rd(input logic [31:0] a);
        if (ram_arr.exists(a)) return ram_arr[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] model_rd(input logic [31:0] a);
        if (model_arr.exists(a)) return model_arr[a];
        return init_byte(a);
    endfunction

    function automatic int unsigned size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // synchronous byte RAM: write on the edge, registered read data
    always @(posedge clk) begin
        if (bus.ram_wr === 1'b1) ram_arr[bus.ram_a] = bus.ram_dout;
        bus.ram_din <= phys_rd(bus.ram_a);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ram_arr[a]   = d;
        model_arr[a] = d;
    endtask

    task automatic check_outputs_zero(input string pfx);
        check_eq({pfx, "_if_done"},   32'(bus.if_done),   '0);
        check_eq({pfx, "_if_inst"},   bus.if_inst,        '0);
        check_eq({pfx, "_mem_done"},  32'(bus.mem_done),  '0);
        check_eq({pfx, "_mem_rdata"}, bus.mem_rdata,      '0);
        check_eq({pfx, "_ram_a"},     bus.ram_a,          '0);
        check_eq({pfx, "_ram_dout"},  32'(bus.ram_dout),  '0);
        check_eq({pfx, "_ram_wr"},    32'(bus.ram_wr),    '0);
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.if_flush  = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_size  = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("rst");
        @(negedge clk);
        rst = 1'b0;
        last_if_inst   = '0;
        last_mem_rdata = '0;
    endtask

    // One complete access starting from IDLE; checks every edge from grant to done.
    task automatic run_access(input bit is_mem, input bit we_in, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input bit flush_during);
        int unsigned n, lat;
        bit          we, exp_wr;
        logic [31:0] exp_a, exp_data;
        logic [7:0]  exp_dout;
        logic        got_done, other_done;
        we  = is_mem && we_in;
        n   = is_mem ? size_bytes(size) : 4;
        lat = we ? n : n + 1;
        exp_data = '0;
        for (int unsigned k = 0; k < n; k++) exp_data[8*k +: 8] = model_rd(addr + 32'(k));

        @(negedge clk);
        if (is_mem) begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = we;
            bus.mem_size  = size;
            bus.mem_addr  = addr;
            bus.mem_wdata = wdata;
            bus.if_flush  = flush_during;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end

        for (int unsigned k = 0; k <= lat; k++) begin
            @(posedge clk);
            #1;
            exp_a    = addr + 32'((k < n) ? k : n - 1);
            exp_wr   = we && (k < n);
            exp_dout = exp_wr ? wdata[8*k +: 8] : 8'h00;
            got_done   = is_mem ? bus.mem_done : bus.if_done;
            other_done = is_mem ? bus.if_done  : bus.mem_done;
            check_eq("ram_a",      bus.ram_a,           exp_a);
            check_eq("ram_wr",     32'(bus.ram_wr),     32'(exp_wr));
            check_eq("ram_dout",   32'(bus.ram_dout),   32'(exp_dout));
            check_eq("done",       32'(got_done),       32'(k == lat));
            check_eq("other_done", 32'(other_done),     '0);
        end

        if (is_mem) begin
            bus.mem_req  = 1'b0;
            bus.if_flush = 1'b0;
        end else begin
            bus.if_req = 1'b0;
        end

        if (we) begin
            for (int unsigned k = 0; k < n; k++) model_arr[addr + 32'(k)] = wdata[8*k +: 8];
        end else if (is_mem) begin
            last_mem_rdata = exp_data;
        end else begin
            last_if_inst = exp_data;
        end
        check_eq("if_inst",   bus.if_inst,   last_if_inst);
        check_eq("mem_rdata", bus.mem_rdata, last_mem_rdata);

        @(posedge clk);
        #1;
        check_eq("done_clr", 32'(bus.if_done | bus.mem_done), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        logic [31:0] a, wd;
        bit          is_mem, we, fl;
        logic [1:0]  sz;

        do_reset();

        // instruction fetch of a known word
        preload(32'h100, 8'h13);
        preload(32'h101, 8'h05);
        preload(32'h102, 8'h00);
        preload(32'h103, 8'h00);
        run_access(1'b0, 1'b0, 2'b10, 32'h100, '0, 1'b0);
        check_eq("if_inst_0x513", bus.if_inst, 32'h0000_0513);

        // half store
        run_access(1'b1, 1'b1, 2'b01, 32'h2000, 32'h1234_BEEF, 1'b0);

        // simultaneous requests: MEM first, IF after DONE plus one IDLE edge
        preload(32'h40, 8'h80);
        @(negedge clk);
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_size = 2'b00; bus.mem_addr = 32'h40;
        bus.if_req  = 1'b1; bus.if_addr = 32'h100;
        @(posedge clk); #1;
        check_eq("arb_grant_mem", bus.ram_a, 32'h40);
        @(posedge clk); #1;
        check_eq("arb_mem_done_early", 32'(bus.mem_done), '0);
        @(posedge clk); #1;
        check_eq("arb_mem_done", 32'(bus.mem_done), 32'd1);
        check_eq("arb_mem_rdata", bus.mem_rdata, 32'h0000_0080);
        check_eq("arb_if_done_early", 32'(bus.if_done), '0);
        bus.mem_req = 1'b0;
        last_mem_rdata = 32'h0000_0080;
        @(posedge clk); #1;
        check_eq("arb_no_grant_in_done", bus.ram_a, 32'h40);
        @(posedge clk); #1;
        check_eq("arb_grant_if", bus.ram_a, 32'h100);
        repeat (4) begin
            @(posedge clk); #1;
            check_eq("arb_if_wait", 32'(bus.if_done), '0);
        end
        @(posedge clk); #1;
        check_eq("arb_if_done", 32'(bus.if_done), 32'd1);
        check_eq("arb_if_inst", bus.if_inst, 32'h0000_0513);
        bus.if_req = 1'b0;
        last_if_inst = 32'h0000_0513;
        @(posedge clk); #1;

        // branch flush in the middle of a fetch
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        bus.if_flush = 1'b1; bus.if_req = 1'b0;
        @(posedge clk); #1;
        bus.if_flush = 1'b0;
        check_eq("flush_ram_wr", 32'(bus.ram_wr), '0);
        repeat (6) begin
            @(posedge clk); #1;
            check_eq("flush_no_done", 32'(bus.if_done), '0);
        end
        check_eq("flush_inst_hold", bus.if_inst, last_if_inst);
        run_access(1'b0, 1'b0, 2'b10, 32'h8, '0, 1'b0);

        // flush together with if_req in IDLE: no grant
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_flush = 1'b1; bus.if_addr = 32'h500;
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("flush_idle_ram_a", bus.ram_a, 32'hB);
            check_eq("flush_idle_done", 32'(bus.if_done), '0);
        end
        @(negedge clk);
        bus.if_req = 1'b0; bus.if_flush = 1'b0;

        // flush is ignored while MEM owns the port
        run_access(1'b1, 1'b0, 2'b10, 32'h2000, '0, 1'b1);

        // asynchronous reset in the middle of a word store
        @(negedge clk);
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_size = 2'b10;
        bus.mem_addr = 32'h3000; bus.mem_wdata = 32'hA1B2_C3D4;
        repeat (3) @(posedge clk);
        #1;
        check_eq("arst_pre_wr", 32'(bus.ram_wr), 32'd1);
        check_eq("arst_pre_dout", 32'(bus.ram_dout), 32'hB2);
        #1;
        rst = 1'b1;
        #1;
        check_outputs_zero("arst");
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        model_arr[32'h3000] = 8'hD4;
        model_arr[32'h3001] = 8'hC3;
        last_if_inst   = '0;
        last_mem_rdata = '0;
        run_access(1'b1, 1'b0, 2'b10, 32'h3000, '0, 1'b0);

        // address wrap past 0xFFFFFFFF
        run_access(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFE, '0, 1'b0);

        // randomized mix
        for (int i = 0; i < 80; i++) begin
            is_mem = 1'($urandom_range(0, 1));
            we     = 1'($urandom_range(0, 1));
            sz     = 2'($urandom_range(0, 3));
            fl     = ($urandom_range(0, 3) == 0);
            wd     = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else                           a = 32'h1000 + 32'($urandom_range(0, 31));
            run_access(is_mem, we, sz, a, wd, is_mem && fl);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
